mips_instr_encoder: RTL and testbench
=====================================

Name: mips_instr_encoder

Overview:
- Inverse of the instruction-decode controller: packs symbolic instruction commands (kind plus register/immediate fields) into 32-bit MIPS words for the same ISA subset.
- Sits on the boot/debug path and streams encoded words, each with an auto-incrementing word address, toward instruction memory.
- Encoded words are buffered in a small FIFO.
- Illegal kinds latch a sticky error and halt intake until the next start.

Parameters:
- DEPTH, 4: output FIFO entries; power of 2, at least 2.
- ADDR_W, 10: width of the word-address counter.
- BASE, 0: address loaded on start.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  pulse: flush FIFO, addr := BASE, clear err, go to RUN
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when valid && ready
- cmd_kind  in  5  instruction kind code, listed below
- cmd_rs, cmd_rt, cmd_rd, cmd_shamt  in  5 each  register and shift fields
- cmd_imm  in  16  immediate or branch offset
- cmd_target  in  26  jump target field
- out_valid  out  1  FIFO head valid
- out_ready  in  1  sink accepts the head word
- out_word  out  32  encoded instruction
- out_addr  out  ADDR_W  word address of out_word
- err  out  1  sticky illegal-kind flag
- words_out  out  16  count of words popped since start, saturating at 0xFFFF

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports are named clk and rst.
- Reset values: state=IDLE; FIFO empty; out_valid=0; out_word=0; out_addr=BASE; err=0; words_out=0; cmd_ready=0.
- FSM states and transitions:
  - IDLE: cmd_ready=0. start moves to RUN.
  - RUN: cmd_ready = FIFO not full. An illegal kind (30 or 31) with cmd_valid moves to ERR; the command is consumed but nothing is pushed.
  - ERR: err=1 and cmd_ready=0. The FIFO keeps draining. start moves to RUN and clears err.
- start has priority over a same-cycle command or pop: FIFO flushed, words_out=0, no push.
- Latency: an accepted command is encoded combinationally and pushed that cycle. out_valid rises on the next cycle.
- Pop on out_valid && out_ready, then out_addr += 1, wrapping modulo 2^ADDR_W.
- Push and pop in the same cycle are allowed when full, but cmd_ready is computed from the registered full flag only. There is no combinational path from out_ready to cmd_ready.
- out_word and out_addr stay stable while out_valid && !out_ready.
- Kind codes and encodings (unused fields are 0):
  - R3, rd/rs/rt, op 0, funct in parentheses: 0 add(20h), 1 addu(21h), 2 sub(22h), 3 and(24h), 4 or(25h), 5 nor(27h), 6 slt(2Ah), 7 sltu(2Bh), 8 sllv(04h), 9 srav(07h).
  - Shift, rd/rt/shamt with rs=0: 10 sll(00h), 11 srl(02h), 12 sra(03h).
  - I-type, rt/rs/imm, op in parentheses: 13 addi(08h), 14 addiu(09h), 15 andi(0Ch), 16 ori(0Dh), 17 slti(0Ah), 19 lw(23h), 20 sw(2Bh), 21 sh(29h).
  - 18 lui: op 0Fh, rs=0.
  - Branches, rs/rt/imm: 22 beq(04h), 23 bne(05h); 24 blez(06h) with rt=0.
  - Jumps: 25 j(02h) and 26 jal(03h) with target; 27 jr = op 0, rs, funct 08h.
  - Fixed words: 28 syscall = 0000000Ch; 29 eret = 42000018h.
- Fields are inserted verbatim; no sign extension or range checks.

Optional Feature:
- Macro: ENC_DELAY_SLOT_NOP_EN.
- When defined:
  - Kinds 22–27 (branches and jumps) push two words in one cycle: the encoded word, then 00000000h (nop in the delay slot).
  - For these kinds, cmd_ready requires at least 2 free entries.
  - The nop receives the next address, and both words count in words_out.
- When undefined: every kind pushes exactly one word.

Test Plan:
- start, then addi rt=8 rs=0 imm=5 with out_ready=1 -> next cycle out_word=20080005h, out_addr=0; words_out=1 after the pop.
- Back-to-back add rd=3 rs=1 rt=2, sll rd=2 rt=3 shamt=4, lw rt=4 rs=29 imm=8 -> 00221820h, 00031100h, 8FA40008h at addresses 0, 1, 2.
- out_ready=0 with DEPTH+1 commands offered -> cmd_ready=0 once 4 words are held; head stable. Release out_ready -> remaining words drain in order.
- kind=31 -> err=1, cmd_ready=0, earlier words still drain. Then start -> err=0, out_addr=BASE, FIFO empty.
- j target=0100000h, syscall, eret -> 08100000h, 0000000Ch, 42000018h. With ENC_DELAY_SLOT_NOP_EN: 08100000h, 00000000h, 0000000Ch, 42000018h.
- rst asserted mid-stream with 3 words queued -> next cycle out_valid=0, out_addr=BASE, words_out=0, state IDLE (cmd_ready=0).

Source files
------------

// File: rtl/mips_instr_encoder.sv
// Packs symbolic MIPS instruction commands into 32-bit words and streams them with word addresses through a small FIFO.
// Optional: define ENC_DELAY_SLOT_NOP_EN to follow every branch/jump with a nop in its delay slot.
module mips_instr_encoder #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 10,
  parameter int BASE   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [4:0]        cmd_kind,
  input  logic [4:0]        cmd_rs,
  input  logic [4:0]        cmd_rt,
  input  logic [4:0]        cmd_rd,
  input  logic [4:0]        cmd_shamt,
  input  logic [15:0]       cmd_imm,
  input  logic [25:0]       cmd_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_word,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  output logic [15:0]       words_out,
  output logic [1:0]        dbg_state
);
  localparam int PW = $clog2(DEPTH);

  // dbg_state encoding: 0 = IDLE, 1 = RUN, 2 = ERR.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_ERR = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [31:0]       mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [PW:0]       count_q, count_d;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       words_q;

  logic [31:0] enc_word;
  logic [5:0]  op, funct;
  logic        illegal, room, accept, push, pop;
  logic [1:0]  n_push;

  // Handshakes: a transfer happens on a clock edge where valid && ready and start is low;
  // ready never depends on the same-side valid, and cmd_ready never depends on out_ready.
  assign illegal   = (cmd_kind[4:1] == 4'b1111);
  assign out_valid = (count_q != '0);
  assign out_word  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign out_addr  = addr_q;
  assign words_out = words_q;
  assign dbg_state = state_q;

  always_comb begin
    op    = 6'h00;
    funct = 6'h00;
    case (cmd_kind)
      5'd0:  funct = 6'h20;
      5'd1:  funct = 6'h21;
      5'd2:  funct = 6'h22;
      5'd3:  funct = 6'h24;
      5'd4:  funct = 6'h25;
      5'd5:  funct = 6'h27;
      5'd6:  funct = 6'h2A;
      5'd7:  funct = 6'h2B;
      5'd8:  funct = 6'h04;
      5'd9:  funct = 6'h07;
      5'd10: funct = 6'h00;
      5'd11: funct = 6'h02;
      5'd12: funct = 6'h03;
      5'd13: op = 6'h08;
      5'd14: op = 6'h09;
      5'd15: op = 6'h0C;
      5'd16: op = 6'h0D;
      5'd17: op = 6'h0A;
      5'd19: op = 6'h23;
      5'd20: op = 6'h2B;
      5'd21: op = 6'h29;
      5'd22: op = 6'h04;
      5'd23: op = 6'h05;
      5'd25: op = 6'h02;
      5'd26: op = 6'h03;
      5'd27: funct = 6'h08;
      default: begin
        op    = 6'h00;
        funct = 6'h00;
      end
    endcase
  end

  always_comb begin
    enc_word = '0;
    case (cmd_kind)
      5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9:
        enc_word = {6'h00, cmd_rs, cmd_rt, cmd_rd, 5'd0, funct};
      5'd10, 5'd11, 5'd12:
        enc_word = {6'h00, 5'd0, cmd_rt, cmd_rd, cmd_shamt, funct};
      5'd13, 5'd14, 5'd15, 5'd16, 5'd17, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23:
        enc_word = {op, cmd_rs, cmd_rt, cmd_imm};
      5'd18:          enc_word = {6'h0F, 5'd0, cmd_rt, cmd_imm};
      5'd24:          enc_word = {6'h06, cmd_rs, 5'd0, cmd_imm};
      5'd25, 5'd26:   enc_word = {op, cmd_target};
      5'd27:          enc_word = {6'h00, cmd_rs, 15'd0, funct};
      5'd28:          enc_word = 32'h0000_000C;
      5'd29:          enc_word = 32'h4200_0018;
      default:        enc_word = '0;
    endcase
  end

`ifdef ENC_DELAY_SLOT_NOP_EN
  logic is_ctl;
  assign is_ctl = (cmd_kind >= 5'd22) && (cmd_kind <= 5'd27);
  assign room   = is_ctl ? (count_q <= (PW+1)'(DEPTH - 2)) : (count_q != (PW+1)'(DEPTH));
  assign n_push = push ? (is_ctl ? 2'd2 : 2'd1) : 2'd0;
`else
  assign room   = (count_q != (PW+1)'(DEPTH));
  assign n_push = push ? 2'd1 : 2'd0;
`endif

  assign accept  = cmd_valid && cmd_ready && !start;
  assign push    = accept && !illegal;
  assign pop     = out_valid && out_ready && !start;
  assign count_d = count_q + (PW+1)'(n_push) - (PW+1)'(pop);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (start) state_d = S_RUN;
               else if (accept && illegal) state_d = S_ERR;
      S_ERR:   if (start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    err       = 1'b0;
    case (state_q)
      S_RUN:   cmd_ready = room;
      S_ERR:   err = 1'b1;
      default: cmd_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || start) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      addr_q   <= ADDR_W'(BASE);
      words_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + PW'(n_push);
      rd_ptr_q <= rd_ptr_q + PW'(pop);
      count_q  <= count_d;
      if (pop) begin
        addr_q <= addr_q + 1'b1;
        if (words_q != 16'hFFFF) words_q <= words_q + 16'd1;
      end
    end
  end

  // Storage carries no reset; out_word is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= enc_word;
`ifdef ENC_DELAY_SLOT_NOP_EN
      if (is_ctl) mem_q[wr_ptr_q + PW'(1)] <= '0;
`endif
    end
  end
endmodule

// File: tb/tb_mips_instr_encoder.sv
// Bench for mips_instr_encoder: directed test-plan vectors plus randomized commands checked against a queue model.
module tb_mips_instr_encoder;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 4;
  localparam int BASE   = 0;
`ifdef ENC_DELAY_SLOT_NOP_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  localparam int R3_FN[10] = '{'h20, 'h21, 'h22, 'h24, 'h25, 'h27, 'h2A, 'h2B, 'h04, 'h07};
  localparam int SH_FN[3]  = '{'h00, 'h02, 'h03};
  localparam int I_OP[9]   = '{'h08, 'h09, 'h0C, 'h0D, 'h0A, 'h0F, 'h23, 'h2B, 'h29};
  localparam int BR_OP[3]  = '{'h04, 'h05, 'h06};

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [4:0]        cmd_kind = '0, cmd_rs = '0, cmd_rt = '0, cmd_rd = '0, cmd_shamt = '0;
  logic [15:0]       cmd_imm = '0;
  logic [25:0]       cmd_target = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [31:0]       out_word;
  logic [ADDR_W-1:0] out_addr;
  logic              err;
  logic [15:0]       words_out;
  logic [1:0]        dbg_state;

  int  n_checks = 0;
  int  n_pass   = 0;
  bit  rand_ready = 1'b0;

  // Reference model: 0 = IDLE, 1 = RUN, 2 = ERR
  logic [31:0] exp_q[$];
  int m_state = 0;
  int m_addr  = BASE;
  int m_words = 0;

  mips_instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE(BASE)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_kind(cmd_kind),
    .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd), .cmd_shamt(cmd_shamt),
    .cmd_imm(cmd_imm), .cmd_target(cmd_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word), .out_addr(out_addr),
    .err(err), .words_out(words_out), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] ref_word(int k, int rs, int rt, int rd, int sh, int imm, int tgt);
    longint w = 0;
    if (k <= 9)       w = rs * 2**21 + rt * 2**16 + rd * 2**11 + R3_FN[k];
    else if (k <= 12) w = rt * 2**16 + rd * 2**11 + sh * 2**6 + SH_FN[k-10];
    else if (k <= 21) w = longint'(I_OP[k-13]) * 2**26 + (k == 18 ? 0 : rs) * 2**21 + rt * 2**16 + imm;
    else if (k <= 24) w = longint'(BR_OP[k-22]) * 2**26 + rs * 2**21 + (k == 24 ? 0 : rt) * 2**16 + imm;
    else if (k <= 26) w = longint'(k - 23) * 2**26 + tgt;
    else if (k == 27) w = rs * 2**21 + 8;
    else if (k == 28) w = 12;
    else if (k == 29) w = 'h42000018;
    return w[31:0];
  endfunction

  // Scoreboard: compare outputs with the model, then advance the model to the next edge.
  always @(negedge clk) begin
    int need;
    bit exp_rdy, do_pop;
    int k;
    k = int'(cmd_kind);
    need = (DS && k >= 22 && k <= 27) ? 2 : 1;
    exp_rdy = (m_state == 1) && (exp_q.size() + need <= DEPTH);
    check32("cmd_ready", cmd_ready, exp_rdy);
    check32("out_valid", out_valid, exp_q.size() > 0);
    check32("out_word", out_word, exp_q.size() > 0 ? exp_q[0] : 32'h0);
    check32("out_addr", out_addr, m_addr);
    check32("err", err, m_state == 2);
    check32("words_out", words_out, m_words);
    check32("dbg_state", dbg_state, m_state);
    if (rst) begin
      exp_q.delete(); m_state = 0; m_addr = BASE; m_words = 0;
    end else if (start) begin
      exp_q.delete(); m_state = 1; m_addr = BASE; m_words = 0;
    end else begin
      do_pop = (exp_q.size() > 0) && out_ready;
      if (do_pop) begin
        void'(exp_q.pop_front());
        m_addr = (m_addr + 1) % (2**ADDR_W);
        if (m_words < 65535) m_words++;
      end
      if (cmd_valid && exp_rdy) begin
        if (k >= 30) m_state = 2;
        else begin
          exp_q.push_back(ref_word(k, cmd_rs, cmd_rt, cmd_rd, cmd_shamt, cmd_imm, cmd_target));
          if (need == 2) exp_q.push_back(32'h0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic send_cmd(input int k, input int rs, input int rt, input int rd, input int sh,
                          input int imm, input int tgt);
    bit done = 1'b0;
    cmd_kind = 5'(k); cmd_rs = 5'(rs); cmd_rt = 5'(rt); cmd_rd = 5'(rd);
    cmd_shamt = 5'(sh); cmd_imm = 16'(imm); cmd_target = 26'(tgt);
    cmd_valid = 1'b1;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk); done = cmd_ready; tick();
    end
    if (!done) check32("cmd_timeout", 0, 1);
    cmd_valid = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [31:0] w, input logic [ADDR_W-1:0] a);
    bit seen = 1'b0;
    for (int i = 0; i < 32 && !seen; i++) begin
      @(negedge clk); seen = out_valid;
    end
    check32({tag, "_valid"}, seen, 1);
    check32({tag, "_word"}, out_word, w);
    check32({tag, "_addr"}, out_addr, a);
    tick(); out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    tick();

    do_start();
    send_cmd(13, 0, 8, 0, 0, 5, 0);
    pop_expect("addi", 32'h20080005, 0);
    @(negedge clk); check32("words_after_pop", words_out, 1); tick();

    do_start();
    send_cmd(0, 1, 2, 3, 0, 0, 0);
    send_cmd(10, 0, 3, 2, 4, 0, 0);
    send_cmd(19, 29, 4, 0, 0, 8, 0);
    pop_expect("add", 32'h00221820, 0);
    pop_expect("sll", 32'h00031100, 1);
    pop_expect("lw", 32'h8FA40008, 2);

    do_start();
    for (int i = 0; i < DEPTH; i++) send_cmd(16, i + 1, i + 2, 0, 0, 'h100 + i, 0);
    cmd_kind = 5'd16; cmd_valid = 1'b1;
    repeat (3) begin
      @(negedge clk); check32("full_ready", cmd_ready, 0); tick();
    end
    out_ready = 1'b1;
    send_cmd(16, 7, 9, 0, 0, 'h1234, 0);
    repeat (8) tick();
    out_ready = 1'b0;

    do_start();
    send_cmd(14, 3, 5, 0, 0, 'hBEEF, 0);
    send_cmd(31, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check32("err_set", err, 1);
    check32("err_ready", cmd_ready, 0);
    tick();
    out_ready = 1'b1; repeat (4) tick(); out_ready = 1'b0;
    do_start();
    @(negedge clk);
    check32("restart_err", err, 0);
    check32("restart_addr", out_addr, BASE);
    check32("restart_valid", out_valid, 0);
    tick();

    send_cmd(25, 0, 0, 0, 0, 0, 'h0100000);
    send_cmd(28, 0, 0, 0, 0, 0, 0);
    send_cmd(29, 0, 0, 0, 0, 0, 0);
`ifdef ENC_DELAY_SLOT_NOP_EN
    pop_expect("j", 32'h08100000, 0);
    pop_expect("nop", 32'h00000000, 1);
    pop_expect("syscall", 32'h0000000C, 2);
    pop_expect("eret", 32'h42000018, 3);
`else
    pop_expect("j", 32'h08100000, 0);
    pop_expect("syscall", 32'h0000000C, 1);
    pop_expect("eret", 32'h42000018, 2);
`endif

    do_start();
    send_cmd(13, 0, 8, 0, 0, 5, 0);
    pop_expect("pre_rst", 32'h20080005, 0);
    for (int i = 0; i < 3; i++) send_cmd(15, 1, 2, 0, 0, 'h0F0F, 0);
    rst = 1'b1; tick(); rst = 1'b0;
    @(negedge clk);
    check32("rst_valid", out_valid, 0);
    check32("rst_addr", out_addr, BASE);
    check32("rst_words", words_out, 0);
    check32("rst_ready", cmd_ready, 0);
    tick();

    rand_ready = 1'b1;
    do_start();
    for (int n = 0; n < 400; n++) begin
      int k;
      k = ($urandom_range(0, 19) == 0) ? int'($urandom_range(30, 31)) : int'($urandom_range(0, 29));
      send_cmd(k, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
               $urandom_range(0, 31), $urandom_range(0, 65535), $urandom_range(0, 2**26 - 1));
      if (m_state == 2) begin
        repeat ($urandom_range(1, 6)) tick();
        do_start();
      end else if ($urandom_range(0, 39) == 0) begin
        do_start();
      end else begin
        repeat ($urandom_range(0, 2)) tick();
      end
    end
    rand_ready = 1'b0;
    out_ready = 1'b1;
    repeat (12) tick();
    out_ready = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
